adder_share_arbiter: RTL and testbench

//  Round-robin arbiter that shares one CarrySelectAdder16Bit among NUM_REQ requesters.

---
 rtl/adder_share_pkg.sv | 42 ++++
 rtl/adder_share_arbiter_if.sv | 37 +++
 rtl/adder_share_arbiter_csa.sv | 33 +++
 rtl/adder_share_arbiter.sv | 129 ++++++++++++
 tb/tb_adder_share_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing arbiter.
//   DATA_W  : operand / result width of the shared adder
//   MAX_REQ : widest requester vector the priority encoder handles
//   state_e : arbiter FSM states
//   pick_t  : result of the rotating priority search (found flag + index)
//   rr_pick : rotating priority encoder used for round-robin granting
package adder_share_pkg;

   localparam int DATA_W  = 16;
   localparam int MAX_REQ = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // Search valid[ptr], valid[ptr+1], ... (mod n) and return the first set bit.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                     input logic [2:0]         ptr,
                                     input int                 n);
      pick_t res;
      int    cand;
      res = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         cand = (int'(ptr) + k) % n;
         if ((k < n) && !res.found && valid[cand[2:0]]) begin
            res.found = 1'b1;
            res.idx   = cand[2:0];
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bus between the client engines and the adder arbiter.
//   req_valid/req_ready : per-requester handshake (one-hot ready)
//   req_a/req_b         : packed operands, requester i in [DATA_W*i +: DATA_W]
//   req_cin             : per-requester carry-in
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/sum/cout     : result tagged with owning requester
//   busy                : an operation is in flight
// master = requester side, slave = arbiter side.
interface adder_share_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   import adder_share_pkg::*;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_a;
   logic [NUM_REQ*DATA_W-1:0] req_b;
   logic [NUM_REQ-1:0]        req_cin;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_sum;
   logic                      rsp_cout;
   logic                      busy;

   modport master (
      output req_valid, req_a, req_b, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );

endinterface

// File: rtl/adder_share_arbiter_csa.sv
// 16-bit carry-select adder: four 4-bit blocks, each precomputing the sum
// for carry-in 0 and 1 and picking one with the incoming block carry.
//   a_i, b_i : operands
//   cin_i    : carry-in
//   sum_o    : (a+b+cin) mod 2^16
//   cout_o   : carry out of bit 15
module CarrySelectAdder16Bit (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        cin_i,
   output logic [15:0] sum_o,
   output logic        cout_o
);

   logic [4:0] carry_s;

   assign carry_s[0] = cin_i;

   for (genvar g = 0; g < 4; g++) begin : g_blk
      logic [4:0] sum0_s;
      logic [4:0] sum1_s;

      // Both candidate block sums are formed before the block carry is known.
      assign sum0_s = {1'b0, a_i[4*g +: 4]} + {1'b0, b_i[4*g +: 4]};
      assign sum1_s = {1'b0, a_i[4*g +: 4]} + {1'b0, b_i[4*g +: 4]} + 5'd1;

      assign sum_o[4*g +: 4] = carry_s[g] ? sum1_s[3:0] : sum0_s[3:0];
      assign carry_s[g+1]    = carry_s[g] ? sum1_s[4]   : sum0_s[4];
   end

   assign cout_o = carry_s[4];

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one CarrySelectAdder16Bit among NUM_REQ requesters.
// IDLE grants one requester and latches its operands, EXEC lets the adder
// settle for a full cycle, RESP holds the tagged result until accepted.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response bus (slave modport), see adder_share_arbiter_if
module adder_share_arbiter
   import adder_share_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   adder_share_arbiter_if.slave bus
);

   state_e             state_q;
   logic [ID_W-1:0]    rr_ptr_q;
   logic [ID_W-1:0]    rr_ptr_d;
   logic [ID_W-1:0]    win_id_s;
   logic [ID_W-1:0]    op_id_q;
   logic [DATA_W-1:0]  op_a_q;
   logic [DATA_W-1:0]  op_b_q;
   logic               op_cin_q;
   logic [DATA_W-1:0]  sel_a_s;
   logic [DATA_W-1:0]  sel_b_s;
   logic               sel_cin_s;
   logic [DATA_W-1:0]  add_sum_s;
   logic               add_cout_s;
   logic [MAX_REQ-1:0] valid_ext_s;
   pick_t              pick_s;
   logic [NUM_REQ-1:0] grant_s;
   logic               rsp_valid_q;
   logic [ID_W-1:0]    rsp_id_q;
   logic [DATA_W-1:0]  rsp_sum_q;
   logic               rsp_cout_q;
   logic               busy_q;

   // Round-robin winner search, grant vector and winner operand mux.
   always_comb begin
      valid_ext_s                = '0;
      valid_ext_s[NUM_REQ-1:0]   = bus.req_valid;
      pick_s                     = rr_pick(valid_ext_s, 3'(rr_ptr_q), NUM_REQ);
      win_id_s                   = pick_s.idx[ID_W-1:0];
      grant_s                    = '0;
      sel_a_s                    = '0;
      sel_b_s                    = '0;
      sel_cin_s                  = 1'b0;
      // AND-OR mux: non-winning slices (possibly X) are masked to zero.
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_s[i] = (state_q == IDLE) && rst_n && pick_s.found && (pick_s.idx == 3'(i));
         sel_a_s    = sel_a_s | ({DATA_W{pick_s.idx == 3'(i)}} & bus.req_a[DATA_W*i +: DATA_W]);
         sel_b_s    = sel_b_s | ({DATA_W{pick_s.idx == 3'(i)}} & bus.req_b[DATA_W*i +: DATA_W]);
         sel_cin_s  = sel_cin_s | ((pick_s.idx == 3'(i)) & bus.req_cin[i]);
      end
      rr_ptr_d = (pick_s.idx == 3'(NUM_REQ-1)) ? '0 : win_id_s + ID_W'(1);
   end

   CarrySelectAdder16Bit u_csa (
      .a_i    (op_a_q),
      .b_i    (op_b_q),
      .cin_i  (op_cin_q),
      .sum_o  (add_sum_s),
      .cout_o (add_cout_s)
   );

   // Arbiter FSM with operand, pointer and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         op_id_q     <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_cin_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_s.found) begin
                  op_a_q   <= sel_a_s;
                  op_b_q   <= sel_b_s;
                  op_cin_q <= sel_cin_s;
                  op_id_q  <= win_id_s;
                  rr_ptr_q <= rr_ptr_d;
                  busy_q   <= 1'b1;
                  state_q  <= EXEC;
               end else begin
                  state_q  <= IDLE;
               end
            end
            EXEC: begin
               rsp_sum_q   <= add_sum_s;
               rsp_cout_q  <= add_cout_s;
               rsp_id_q    <= op_id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               // New grants wait for the following IDLE cycle.
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  state_q     <= RESP;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = grant_s;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (NUM_REQ=4).
module tb_adder_share_arbiter;
   import adder_share_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   adder_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

   adder_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated operation on requester i with rsp_ready pulsed once the result is up.
   task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [16:0] exp, input string tag);
      logic [3:0] oh;
      oh = 4'b0000;
      oh[i] = 1'b1;
      bus.rsp_ready = 1'b0;
      bus.req_a[16*i +: 16] = a;
      bus.req_b[16*i +: 16] = b;
      bus.req_cin = 4'bxxxx;
      bus.req_cin[i] = cin;
      bus.req_valid = oh;
      #1;
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'(oh));
      tick();
      bus.req_valid = 4'b0000;
      #1;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_early"}, 32'(bus.rsp_valid), 32'd0);
      tick();
      chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, "_id"}, 32'(bus.rsp_id), 32'(i));
      chk({tag, "_sum"}, 32'(bus.rsp_sum), 32'(exp[15:0]));
      chk({tag, "_cout"}, 32'(bus.rsp_cout), 32'(exp[16]));
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk({tag, "_done"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rr_sum [4];
      logic [3:0]  oh;
      rr_sum = '{16'h0111, 16'h0212, 16'h0311, 16'h0412};

      // Test 1/2: reset with everyone requesting, then a single op on req0.
      rst_n         = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b1111;
      bus.req_a     = {16'h0000, 16'h0000, 16'h0000, 16'h000F};
      bus.req_b     = {16'h0000, 16'h0000, 16'h0000, 16'h0003};
      bus.req_cin   = 4'b0001;
      tick();
      tick();
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_sum", 32'(bus.rsp_sum), 32'd0);
      chk("rst_cout", 32'(bus.rsp_cout), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("first_grant", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = 4'b0000;
      #1;
      chk("single_busy", 32'(bus.busy), 32'd1);
      chk("single_early", 32'(bus.rsp_valid), 32'd0);
      tick();
      chk("single_valid", 32'(bus.rsp_valid), 32'd1);
      chk("single_sum", 32'(bus.rsp_sum), 32'h0013);
      chk("single_cout", 32'(bus.rsp_cout), 32'd0);
      chk("single_id", 32'(bus.rsp_id), 32'd0);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("single_done", 32'(bus.rsp_valid), 32'd0);

      // Test 3: wrap-around cases on requester 2.
      do_op(2, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, "wrap1");
      do_op(2, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, "wrap2");

      // Test 6a: reset during EXEC discards the op and clears rr_ptr.
      bus.req_a[48 +: 16] = 16'h0101;
      bus.req_b[48 +: 16] = 16'h0202;
      bus.req_cin   = 4'b0000;
      bus.req_valid = 4'b1000;
      #1;
      chk("midrst_grant", 32'(bus.req_ready), 32'h8);
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_ready", 32'(bus.req_ready), 32'd0);
      tick();
      tick();
      chk("midrst_valid2", 32'(bus.rsp_valid), 32'd0);

      // Test 4: all requesters valid, rsp_ready high -> ids 0,1,2,3,0 every 3 cycles.
      bus.req_a     = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
      bus.req_b     = {16'h0011, 16'h0011, 16'h0011, 16'h0011};
      bus.req_cin   = 4'b1010;
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      rst_n         = 1'b1;
      #1;
      for (int t = 0; t < 15; t++) begin
         if (t > 0) tick();
         chk($sformatf("rr_valid_t%0d", t), 32'(bus.rsp_valid), 32'((t % 3) == 2));
         if ((t % 3) == 2) begin
            chk($sformatf("rr_id_t%0d", t), 32'(bus.rsp_id), 32'((t / 3) % 4));
            chk($sformatf("rr_sum_t%0d", t), 32'(bus.rsp_sum), 32'(rr_sum[(t / 3) % 4]));
         end
         if ((t % 3) == 0) begin
            oh = 4'b0000;
            oh[(t / 3) % 4] = 1'b1;
            chk($sformatf("rr_grant_t%0d", t), 32'(bus.req_ready), 32'(oh));
         end
      end
      tick();
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b0;
      #1;

      // Test 5: backpressure on a req0 result while req1 waits.
      bus.req_a     = {16'h0000, 16'h0000, 16'h8000, 16'h1234};
      bus.req_b     = {16'h0000, 16'h0000, 16'h8000, 16'h4321};
      bus.req_cin   = 4'b0010;
      bus.req_valid = 4'b0001;
      #1;
      chk("bp_grant0", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = 4'b0010;
      #1;
      chk("bp_exec_ready", 32'(bus.req_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_sum", 32'(bus.rsp_sum), 32'h5555);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("bp_hold_valid_%0d", k), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("bp_hold_sum_%0d", k), 32'(bus.rsp_sum), 32'h5555);
         chk($sformatf("bp_hold_id_%0d", k), 32'(bus.rsp_id), 32'd0);
         chk($sformatf("bp_hold_ready_%0d", k), 32'(bus.req_ready), 32'd0);
         chk($sformatf("bp_hold_busy_%0d", k), 32'(bus.busy), 32'd1);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("bp_grant1", 32'(bus.req_ready), 32'h2);
      chk("bp_released", 32'(bus.rsp_valid), 32'd0);
      tick();
      bus.req_valid = 4'b0000;
      tick();
      chk("bp1_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp1_sum", 32'(bus.rsp_sum), 32'h0001);
      chk("bp1_cout", 32'(bus.rsp_cout), 32'd1);
      chk("bp1_id", 32'(bus.rsp_id), 32'd1);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("bp1_done", 32'(bus.rsp_valid), 32'd0);

      // Test 6b: small exhaustive sweep against a+b+cin, plus high-nibble variants.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               do_op(a % 4, 16'(a), 16'(b), 1'(c), 17'(a + b + c), "exh");
            end
         end
      end
      for (int a = 0; a < 16; a++) begin
         do_op((a + 1) % 4, 16'(a << 12), 16'(15 - a) << 12, 1'(a % 2),
               17'((a << 12) + ((15 - a) << 12) + (a % 2)), "exh_hi");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
